// File: rtl/opb_register_bank_simulink2ppc_pkg.sv
// Shared constants for the OPB register bank: CTRL layout, slave FSM states, counter width.
package opb_regbank_pkg;

  localparam int unsigned CTRL_WORD      = 0;
  localparam int unsigned CTRL_MODE_BIT  = 31;
  localparam int unsigned CTRL_SNAP_BIT  = 30;
  localparam int unsigned CTRL_COUNT_POS = 0;
  localparam int unsigned COUNT_W        = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } slave_state_e;

endpackage

// File: rtl/opb_register_bank_simulink2ppc_if.sv
// OPB bus signals between the bus master (PowerPC side) and this slave; big-endian bit order.
interface opb_register_bank_simulink2ppc_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);

  logic [0:AWIDTH-1]   OPB_ABus;
  logic [0:DWIDTH/8-1] OPB_BE;
  logic [0:DWIDTH-1]   OPB_DBus;
  logic                OPB_RNW;
  logic                OPB_select;
  logic                OPB_seqAddr;
  logic [0:DWIDTH-1]   Sl_DBus;
  logic                Sl_xferAck;
  logic                Sl_errAck;
  logic                Sl_retry;
  logic                Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

endinterface

// File: rtl/opb_register_bank_simulink2ppc_decode.sv
// OPB slave front end: window check, word index, IDLE/ACK handshake and gated read data.
module opb_slave_decode
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  opb_register_bank_simulink2ppc_if.slave bus,
  output logic [C_OPB_AWIDTH-3:0]         word_idx,
  input  logic [0:C_OPB_DWIDTH-1]         rd_data,
  output logic                            ctrl_wr,
  output logic                            ctrl_wr_mode,
  output logic                            ctrl_wr_snap
);

  localparam int BE_LAST = C_OPB_DWIDTH / 8 - 1;
  localparam logic [C_OPB_AWIDTH-1:0] BASE = C_BASEADDR[C_OPB_AWIDTH-1:0];
  localparam logic [C_OPB_AWIDTH-1:0] SPAN = C_HIGHADDR[C_OPB_AWIDTH-1:0] - BASE;
  localparam logic [C_OPB_AWIDTH-3:0] CTRL_IDX = CTRL_WORD[C_OPB_AWIDTH-3:0];

  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH:0]   diff;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic                    hit;
  logic                    is_ctrl;

  slave_state_e            state_q, state_d;
  logic                    ack_q, ack_d;
  logic [0:C_OPB_DWIDTH-1] dbus_q, dbus_d;
  logic                    wr_pend_q, wr_pend_d;
  logic                    wr_mode_q, wr_mode_d;
  logic                    wr_snap_q, wr_snap_d;
  logic                    unused_bus;

  // The extra top bit of diff is the borrow: set when the address lies below the window.
  assign addr     = bus.OPB_ABus;
  assign diff     = {1'b0, addr} - {1'b0, BASE};
  assign offset   = diff[C_OPB_AWIDTH-1:0];
  assign hit      = bus.OPB_select && !diff[C_OPB_AWIDTH] && (offset <= SPAN);
  assign word_idx = offset[C_OPB_AWIDTH-1:2];
  assign is_ctrl  = (word_idx == CTRL_IDX);

  assign unused_bus = ^{bus.OPB_seqAddr, bus.OPB_DBus, bus.OPB_BE, offset[1:0]};

  // Next-state logic: one ack per hit, read data captured on the hit edge, CTRL write latched for the ACK edge.
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    dbus_d    = '0;
    wr_pend_d = wr_pend_q;
    wr_mode_d = wr_mode_q;
    wr_snap_d = wr_snap_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d   = ST_ACK;
          ack_d     = 1'b1;
          if (bus.OPB_RNW) begin
            dbus_d = rd_data;
          end
          wr_pend_d = !bus.OPB_RNW && is_ctrl && bus.OPB_BE[BE_LAST];
          wr_mode_d = bus.OPB_DBus[CTRL_MODE_BIT];
          wr_snap_d = bus.OPB_DBus[CTRL_SNAP_BIT];
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slave FSM and its registered bus outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      dbus_q    <= '0;
      wr_pend_q <= 1'b0;
      wr_mode_q <= 1'b0;
      wr_snap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      dbus_q    <= dbus_d;
      wr_pend_q <= wr_pend_d;
      wr_mode_q <= wr_mode_d;
      wr_snap_q <= wr_snap_d;
    end
  end

  assign ctrl_wr        = (state_q == ST_ACK) && wr_pend_q;
  assign ctrl_wr_mode   = wr_mode_q;
  assign ctrl_wr_snap   = wr_snap_q;

  assign bus.Sl_xferAck = ack_q;
  assign bus.Sl_DBus    = dbus_q;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Read-only user channel bank with coherent snapshot capture and a CTRL/status register.
module opb_register_bank_simulink2ppc
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR        = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR        = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH      = 32,
  parameter int          C_OPB_DWIDTH      = 32,
  parameter int          C_NUM_CH          = 4,
  parameter int          C_DWIDTH          = 32,
  parameter int          C_SNAP_RESET_MODE = 1
) (
  input  logic                            OPB_Clk,
  input  logic                            OPB_Rst_n,
  opb_register_bank_simulink2ppc_if.slave bus,
  input  logic [C_NUM_CH*C_DWIDTH-1:0]    user_data_in,
  input  logic                            user_snap,
  output logic                            snap_done
);

  localparam int IW = C_OPB_AWIDTH - 2;
  localparam int UW = C_NUM_CH * C_DWIDTH;
  localparam logic [IW-1:0] CTRL_IDX = CTRL_WORD[IW-1:0];

  logic [IW-1:0]           word_idx;
  logic [0:C_OPB_DWIDTH-1] rd_data;
  logic                    ctrl_wr;
  logic                    ctrl_wr_mode;
  logic                    ctrl_wr_snap;
  logic                    capture;
  logic [C_DWIDTH-1:0]     chan_sel;

  logic [UW-1:0]           snap_q, snap_d;
  logic [UW-1:0]           live_q, live_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic                    mode_q, mode_d;
  logic                    snap_done_q, snap_done_d;

  opb_slave_decode #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_OPB_DWIDTH (C_OPB_DWIDTH)
  ) u_decode (
    .clk          (OPB_Clk),
    .rst_n        (OPB_Rst_n),
    .bus          (bus),
    .word_idx     (word_idx),
    .rd_data      (rd_data),
    .ctrl_wr      (ctrl_wr),
    .ctrl_wr_mode (ctrl_wr_mode),
    .ctrl_wr_snap (ctrl_wr_snap)
  );

  // A fabric strobe and a software request in the same cycle merge into a single capture.
  always_comb begin
    capture     = user_snap || (ctrl_wr && ctrl_wr_snap);
    mode_d      = ctrl_wr ? ctrl_wr_mode : mode_q;
    snap_d      = capture ? user_data_in : snap_q;
    count_d     = capture ? count_q + COUNT_W'(1) : count_q;
    snap_done_d = capture;
    live_d      = user_data_in;
  end

  // Snapshot bank, live pipeline register, capture counter and mode bit.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      snap_q      <= '0;
      live_q      <= '0;
      count_q     <= '0;
      mode_q      <= (C_SNAP_RESET_MODE != 0);
      snap_done_q <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      live_q      <= live_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      snap_done_q <= snap_done_d;
    end
  end

  // Read mux: CTRL, one channel (snapshot or live by mode), or zero for unused words.
  always_comb begin
    rd_data  = '0;
    chan_sel = '0;
    if (word_idx == CTRL_IDX) begin
      rd_data[CTRL_MODE_BIT]            = mode_q;
      rd_data[CTRL_COUNT_POS +: COUNT_W] = count_q;
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (word_idx == IW'(i + 1)) begin
          chan_sel = mode_q ? snap_q[i*C_DWIDTH +: C_DWIDTH] : live_q[i*C_DWIDTH +: C_DWIDTH];
        end
      end
      rd_data[C_OPB_DWIDTH-C_DWIDTH +: C_DWIDTH] = chan_sel;
    end
  end

  assign snap_done = snap_done_q;

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Randomised scoreboard bench for the OPB register bank with a behavioural register model.
`timescale 1ns/1ps
module tb_opb_register_bank_simulink2ppc;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] HIGH = 32'h0000_00FF;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH*DW-1:0] user_data_in;
  logic                 user_snap;
  logic                 snap_done;

  opb_register_bank_simulink2ppc_if bus_if ();

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks     = 0;
  int          errors     = 0;
  int          snaps_exp  = 0;
  int          snaps_seen = 0;
  logic [31:0] chan_in[NUM_CH];
  logic [31:0] snap_m[NUM_CH];
  logic        mode_m;
  int          count_m;

  always #5 clk = ~clk;

  opb_register_bank_simulink2ppc #(
    .C_BASEADDR        (BASE),
    .C_HIGHADDR        (HIGH),
    .C_OPB_AWIDTH      (32),
    .C_OPB_DWIDTH      (32),
    .C_NUM_CH          (NUM_CH),
    .C_DWIDTH          (DW),
    .C_SNAP_RESET_MODE (1)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .bus          (bus_if),
    .user_data_in (user_data_in),
    .user_snap    (user_snap),
    .snap_done    (snap_done)
  );

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endfunction

  function automatic void driveInputs();
    for (int i = 0; i < NUM_CH; i++) user_data_in[i*DW +: DW] = chan_in[i];
  endfunction

  function automatic void randomizeInputs();
    for (int i = 0; i < NUM_CH; i++) chan_in[i] = $urandom;
    driveInputs();
  endfunction

  function automatic void modelReset();
    mode_m  = 1'b1;
    count_m = 0;
    for (int i = 0; i < NUM_CH; i++) snap_m[i] = 32'h0;
  endfunction

  function automatic void modelCapture();
    for (int i = 0; i < NUM_CH; i++) snap_m[i] = chan_in[i];
    count_m = (count_m + 1) % 65536;
    snaps_exp++;
  endfunction

  // Expected read value straight from the register map rules.
  function automatic logic [31:0] expRead(logic [31:0] addr);
    logic [31:0] k;
    k = (addr - BASE) >> 2;
    if (k == 0) return (32'(count_m) << 16) | {31'h0, mode_m};
    if (k <= NUM_CH) return mode_m ? snap_m[k-1] : chan_in[k-1];
    return 32'h0;
  endfunction

  // One OPB transfer; the expected ack payload goes to the scoreboard, the model updates afterwards.
  task automatic applyStimulus(input string name, input logic [31:0] addr, input bit rnw,
                               input logic [31:0] wdata, input logic [3:0] be, input bit pulse_snap);
    bit          in_win;
    bit          cap;
    logic [31:0] k;
    exp_t        e;
    in_win = (addr >= BASE) && (addr <= HIGH);
    k      = (addr - BASE) >> 2;
    cap    = pulse_snap;
    @(posedge clk); #1;
    if (in_win) begin
      e.name = name;
      e.data = rnw ? expRead(addr) : 32'h0;
      sb_q.push_back(e);
    end
    bus_if.OPB_ABus   = addr;
    bus_if.OPB_RNW    = rnw;
    bus_if.OPB_DBus   = wdata;
    bus_if.OPB_BE     = be;
    bus_if.OPB_select = 1'b1;
    @(posedge clk); #1;
    if (pulse_snap) user_snap = 1'b1;
    @(negedge clk);
    checkOutput({name, "_ack"}, {31'h0, bus_if.Sl_xferAck}, {31'h0, in_win});
    @(posedge clk); #1;
    user_snap         = 1'b0;
    bus_if.OPB_select = 1'b0;
    bus_if.OPB_RNW    = 1'b0;
    bus_if.OPB_DBus   = 32'h0;
    bus_if.OPB_BE     = 4'h0;
    if (in_win && !rnw && k == 0 && be[0]) begin
      mode_m = wdata[0];
      if (wdata[1]) cap = 1'b1;
    end
    if (cap) modelCapture();
  endtask

  task automatic pulseSnap(input int n);
    if (n <= 0) return;
    @(posedge clk); #1;
    user_snap = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    user_snap = 1'b0;
    repeat (n) modelCapture();
  endtask

  task automatic checkSnapDone(input string name);
    repeat (2) @(posedge clk);
    checkOutput(name, 32'(snaps_seen), 32'(snaps_exp));
  endtask

  // Monitor: every ack pops the scoreboard; between acks the read bus must stay zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.Sl_xferAck) begin
        if (sb_q.size() == 0) begin
          checkOutput("spurious_ack", {31'h0, bus_if.Sl_xferAck}, 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput(mon_e.name, bus_if.Sl_DBus, mon_e.data);
        end
      end else begin
        checkOutput("idle_dbus", bus_if.Sl_DBus, 32'h0);
      end
      if (snap_done) snaps_seen++;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    bus_if.OPB_ABus    = 32'h0;
    bus_if.OPB_BE      = 4'h0;
    bus_if.OPB_DBus    = 32'h0;
    bus_if.OPB_RNW     = 1'b0;
    bus_if.OPB_select  = 1'b0;
    bus_if.OPB_seqAddr = 1'b0;
    user_snap          = 1'b0;
    for (int i = 0; i < NUM_CH; i++) chan_in[i] = 32'h0;
    driveInputs();
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ack", {31'h0, bus_if.Sl_xferAck}, 32'h0);
    checkOutput("reset_dbus", bus_if.Sl_DBus, 32'h0);
    checkOutput("reset_snap_done", {31'h0, snap_done}, 32'h0);
    checkOutput("tied_outputs", {29'h0, bus_if.Sl_errAck, bus_if.Sl_retry, bus_if.Sl_toutSup}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("rd_ctrl_reset", BASE, 1'b1, 32'h0, 4'hF, 1'b0);

    chan_in[0] = 32'h1234_5678;
    for (int i = 1; i < NUM_CH; i++) chan_in[i] = $urandom;
    driveInputs();
    applyStimulus("wr_ctrl_snap", BASE, 1'b0, 32'h0000_0003, 4'hF, 1'b0);
    randomizeInputs();
    applyStimulus("rd_ch0_snap", BASE + 32'd4, 1'b1, 32'h0, 4'hF, 1'b0);
    applyStimulus("rd_ctrl_count1", BASE, 1'b1, 32'h0, 4'hF, 1'b0);
    checkSnapDone("snap_done_first");

    applyStimulus("wr_ctrl_live", BASE, 1'b0, 32'h0, 4'hF, 1'b0);
    chan_in[1] = 32'hDEAD_BEEF;
    driveInputs();
    applyStimulus("rd_ch1_live", BASE + 32'd8, 1'b1, 32'h0, 4'hF, 1'b0);
    applyStimulus("rd_ctrl_live", BASE, 1'b1, 32'h0, 4'hF, 1'b0);

    randomizeInputs();
    applyStimulus("wr_ctrl_snap_with_strobe", BASE, 1'b0, 32'h0000_0003, 4'hF, 1'b1);
    applyStimulus("rd_ctrl_after_dual", BASE, 1'b1, 32'h0, 4'hF, 1'b0);
    checkSnapDone("snap_done_dual");

    applyStimulus("wr_ctrl_be_off", BASE, 1'b0, 32'h0000_0002, 4'hE, 1'b0);
    applyStimulus("rd_ctrl_be_off", BASE, 1'b1, 32'h0, 4'hF, 1'b0);

    randomizeInputs();
    applyStimulus("rd_ch2_during_capture", BASE + 32'd12, 1'b1, 32'h0, 4'hF, 1'b1);
    applyStimulus("rd_ch2_after_capture", BASE + 32'd12, 1'b1, 32'h0, 4'hF, 1'b0);

    applyStimulus("rd_beyond_channels", BASE + 32'(4 * (NUM_CH + 1)), 1'b1, 32'h0, 4'hF, 1'b0);
    applyStimulus("rd_top_of_window", HIGH, 1'b1, 32'h0, 4'hF, 1'b0);
    applyStimulus("wr_ch0_discard", BASE + 32'd4, 1'b0, 32'hFFFF_FFFF, 4'hF, 1'b0);
    applyStimulus("rd_ch0_after_wr", BASE + 32'd4, 1'b1, 32'h0, 4'hF, 1'b0);
    applyStimulus("rd_outside_window", HIGH + 32'd4, 1'b1, 32'h0, 4'hF, 1'b0);
    applyStimulus("rd_ctrl_after_outside", BASE, 1'b1, 32'h0, 4'hF, 1'b0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: randomizeInputs();
        1: applyStimulus("rnd_rd_ctrl", BASE + 32'($urandom_range(0, 3)), 1'b1, 32'h0, 4'hF, 1'b0);
        2: applyStimulus("rnd_rd_word", BASE + 32'(4 * $urandom_range(0, NUM_CH + 2)) + 32'($urandom_range(0, 3)),
                         1'b1, 32'h0, 4'hF, 1'b0);
        3: applyStimulus("rnd_wr_ctrl", BASE, 1'b0, $urandom, 4'($urandom_range(0, 15)), 1'b0);
        4: pulseSnap($urandom_range(1, 3));
        default: applyStimulus("rnd_rd_ch_strobe", BASE + 32'(4 * $urandom_range(1, NUM_CH)),
                               1'b1, 32'h0, 4'hF, 1'b1);
      endcase
    end
    checkSnapDone("snap_done_random");

    pulseSnap(65535 - count_m);
    applyStimulus("rd_ctrl_count_ffff", BASE, 1'b1, 32'h0, 4'hF, 1'b0);
    pulseSnap(1);
    applyStimulus("rd_ctrl_count_wrap", BASE, 1'b1, 32'h0, 4'hF, 1'b0);
    checkSnapDone("snap_done_wrap");

    applyStimulus("wr_ctrl_live_pre_rst", BASE, 1'b0, 32'h0, 4'hF, 1'b0);
    pulseSnap(2);
    checkSnapDone("snap_done_pre_rst");
    @(posedge clk); #1;
    bus_if.OPB_ABus   = BASE;
    bus_if.OPB_RNW    = 1'b1;
    bus_if.OPB_BE     = 4'hF;
    bus_if.OPB_select = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ack", {31'h0, bus_if.Sl_xferAck}, 32'h0);
    checkOutput("midrst_dbus", bus_if.Sl_DBus, 32'h0);
    checkOutput("midrst_snap_done", {31'h0, snap_done}, 32'h0);
    @(posedge clk); #1;
    checkOutput("midrst_ack_held", {31'h0, bus_if.Sl_xferAck}, 32'h0);
    bus_if.OPB_select = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus("rd_ctrl_after_rst", BASE, 1'b1, 32'h0, 4'hF, 1'b0);
    applyStimulus("rd_ch0_after_rst", BASE + 32'd4, 1'b1, 32'h0, 4'hF, 1'b0);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    checkSnapDone("snap_done_final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
